// File: rtl/sdram_arbiter.sv
// Two-port SDRAM command arbiter (CPU port A, DMA port B, refresh) with starvation guard.
// Latency: command one cycle after the request, ack CYC cycles after the command.
// Backpressure: requests stay pending while ready is low or a command is in flight; aborts are retried.
module sdram_arbiter #(
    parameter int CYC    = 8,
    parameter int STARVE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic        aRd,
    input  logic        aWr,
    input  logic [23:0] aA,
    input  logic [7:0]  aD,
    output logic [7:0]  aQ,
    output logic        aAck,
    input  logic        bReq,
    input  logic        bWe,
    input  logic [23:0] bA,
    input  logic [15:0] bD,
    output logic [15:0] bQ,
    output logic        bAck,
    input  logic        rfReq,
    output logic        sdrRf,
    output logic        sdrRd,
    output logic        sdrWr,
    output logic [23:0] sdrA,
    output logic [15:0] sdrD,
    input  logic [15:0] sdrQ
);

    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] G_RF = 2'd0;
    localparam logic [1:0] G_A  = 2'd1;
    localparam logic [1:0] G_B  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    gnt;
    logic          g_wr;
    logic [3:0]    cnt;
    logic [SW-1:0] st_cnt;
    logic          a_pend;
    logic          a_wr;
    logic          a_rearm;
    logic [23:0]   a_addr;
    logic [7:0]    a_dat;
    logic          rf_pend;
    logic [15:0]   q_lat;

    logic          a_stb;
    logic          b_pend;
    logic          rf_any;
    logic          a_any;
    logic          starve_hit;
    logic          start;
    logic          go_rf;
    logic          go_a;
    logic          go_b;
    logic [23:0]   a_sel_addr;
    logic [7:0]    a_sel_dat;
    logic          a_sel_wr;

    // Strobes arriving this cycle are eligible for an immediate grant.
    assign a_stb      = aRd | aWr;
    assign b_pend     = bReq & ~bAck;
    assign rf_any     = rf_pend | rfReq;
    assign a_any      = a_pend | a_stb;
    assign starve_hit = b_pend && (st_cnt == SW'(STARVE));
    assign start      = (state == IDLE) && ready && (rf_any || a_any || b_pend);
    assign go_rf      = start && rf_any;
    assign go_a       = start && !rf_any && a_any && !starve_hit;
    assign go_b       = start && !rf_any && !go_a;

    assign a_sel_addr = a_pend ? a_addr : aA;
    assign a_sel_dat  = a_pend ? a_dat  : aD;
    assign a_sel_wr   = a_pend ? a_wr   : aWr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= G_RF;
            g_wr    <= 1'b0;
            cnt     <= '0;
            st_cnt  <= '0;
            a_pend  <= 1'b0;
            a_wr    <= 1'b0;
            a_rearm <= 1'b0;
            a_addr  <= '0;
            a_dat   <= '0;
            rf_pend <= 1'b0;
            q_lat   <= '0;
            aQ      <= '0;
            aAck    <= 1'b0;
            bQ      <= '0;
            bAck    <= 1'b0;
            sdrRf   <= 1'b0;
            sdrRd   <= 1'b0;
            sdrWr   <= 1'b0;
            sdrA    <= '0;
            sdrD    <= '0;
        end else begin
            sdrRf <= 1'b0;
            sdrRd <= 1'b0;
            sdrWr <= 1'b0;
            aAck  <= 1'b0;
            bAck  <= 1'b0;

            if (a_stb) begin
                a_pend <= 1'b1;
                a_addr <= aA;
                a_dat  <= aD;
                a_wr   <= aWr;
            end
            if (rfReq) rf_pend <= 1'b1;

            // A strobe seen during an A service must survive that service's completion.
            if (state == IDLE) a_rearm <= a_pend & a_stb;
            else if (a_stb)    a_rearm <= 1'b1;

            if (!b_pend || go_b)                   st_cnt <= '0;
            else if (go_a && st_cnt != SW'(STARVE)) st_cnt <= st_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= 4'(CYC - 2);
                        if (go_rf) begin
                            gnt   <= G_RF;
                            g_wr  <= 1'b0;
                            sdrRf <= 1'b1;
                        end else if (go_a) begin
                            gnt   <= G_A;
                            g_wr  <= a_sel_wr;
                            sdrWr <= a_sel_wr;
                            sdrRd <= ~a_sel_wr;
                            sdrA  <= a_sel_addr;
                            sdrD  <= {a_sel_dat, a_sel_dat};
                        end else begin
                            gnt   <= G_B;
                            g_wr  <= bWe;
                            sdrWr <= bWe;
                            sdrRd <= ~bWe;
                            sdrA  <= bA;
                            sdrD  <= bD;
                        end
                    end
                end
                BUSY: begin
                    if (!ready) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        q_lat <= sdrQ;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (ready) begin
                        if (gnt == G_A) begin
                            aAck   <= 1'b1;
                            a_pend <= a_rearm | a_stb;
                            if (!g_wr) aQ <= q_lat[7:0];
                        end else if (gnt == G_B) begin
                            bAck <= 1'b1;
                            if (!g_wr) bQ <= q_lat;
                        end else begin
                            rf_pend <= rfReq;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised and directed bench for sdram_arbiter against a slot-based transaction model.
module tb_sdram_arbiter;

    localparam int CYC    = 5;
    localparam int STARVE = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ready = 1'b0;
    logic        aRd = 1'b0, aWr = 1'b0;
    logic [23:0] aA = '0;
    logic [7:0]  aD = '0;
    logic [7:0]  aQ;
    logic        aAck;
    logic        bReq = 1'b0, bWe = 1'b0;
    logic [23:0] bA = '0;
    logic [15:0] bD = '0;
    logic [15:0] bQ;
    logic        bAck;
    logic        rfReq = 1'b0;
    logic        sdrRf, sdrRd, sdrWr;
    logic [23:0] sdrA;
    logic [15:0] sdrD;
    logic [15:0] sdrQ = '0;

    sdram_arbiter #(.CYC(CYC), .STARVE(STARVE)) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .aRd(aRd), .aWr(aWr), .aA(aA), .aD(aD), .aQ(aQ), .aAck(aAck),
        .bReq(bReq), .bWe(bWe), .bA(bA), .bD(bD), .bQ(bQ), .bAck(bAck),
        .rfReq(rfReq), .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr),
        .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: one in-flight command plus "waiting" slots per requester.
    bit          m_busy;
    int          m_age, m_kind;
    bit          m_wr;
    logic [15:0] m_q;
    bit          aw_v, aw_wr, af_wr, rf_w;
    logic [23:0] aw_a, af_a;
    logic [7:0]  aw_d, af_d;
    int          starve;
    logic        e_rf, e_rd, e_wr, e_aack, e_back;
    logic [23:0] e_sdrA;
    logic [15:0] e_sdrD, e_bQ;
    logic [7:0]  e_aQ;

    int          t_cmd[$];
    logic [2:0]  k_cmd[$];
    logic [15:0] d_cmd[$];
    int          ncyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_age = 0; m_kind = 0; m_wr = 0; m_q = '0;
        aw_v = 0; aw_wr = 0; af_wr = 0; rf_w = 0;
        aw_a = '0; af_a = '0; aw_d = '0; af_d = '0; starve = 0;
        e_rf = 0; e_rd = 0; e_wr = 0; e_aack = 0; e_back = 0;
        e_sdrA = '0; e_sdrD = '0; e_aQ = '0; e_bQ = '0;
    endtask

    task automatic m_edge();
        bit a_stb, b_pend, rf_keep, a_used, g_a, g_b;
        bit n_rf, n_rd, n_wr, n_aack, n_back;
        a_stb = aRd | aWr;
        b_pend = bReq && !e_back;
        rf_keep = 1; a_used = 0; g_a = 0; g_b = 0;
        n_rf = 0; n_rd = 0; n_wr = 0; n_aack = 0; n_back = 0;
        if (!m_busy) begin
            if (ready && (rf_w || rfReq || aw_v || a_stb || b_pend)) begin
                m_busy = 1; m_age = 0;
                if (rf_w || rfReq) begin
                    m_kind = 0; n_rf = 1; rf_w = 0; rf_keep = 0;
                end else if ((aw_v || a_stb) && !(b_pend && starve == STARVE)) begin
                    m_kind = 1; g_a = 1;
                    if (aw_v) begin
                        af_a = aw_a; af_d = aw_d; af_wr = aw_wr; aw_v = 0;
                    end else begin
                        af_a = aA; af_d = aD; af_wr = aWr; a_used = 1;
                    end
                    m_wr = af_wr; n_wr = af_wr; n_rd = !af_wr;
                    e_sdrA = af_a; e_sdrD = {af_d, af_d};
                end else begin
                    m_kind = 2; g_b = 1; m_wr = bWe; n_wr = bWe; n_rd = !bWe;
                    e_sdrA = bA; e_sdrD = bD;
                end
            end
        end else if (!ready) begin
            m_busy = 0;
            if (m_kind == 1 && !aw_v) begin
                aw_v = 1; aw_a = af_a; aw_d = af_d; aw_wr = af_wr;
            end
            if (m_kind == 0) rf_w = 1;
        end else if (m_age == CYC - 1) begin
            m_busy = 0;
            if (m_kind == 1) begin
                n_aack = 1;
                if (!m_wr) e_aQ = m_q[7:0];
            end else if (m_kind == 2) begin
                n_back = 1;
                if (!m_wr) e_bQ = m_q;
            end
        end else begin
            if (m_age == CYC - 2) m_q = sdrQ;
            m_age++;
            if (m_kind == 0) rf_keep = 0;
        end
        if (a_stb && !a_used) begin
            aw_v = 1; aw_a = aA; aw_d = aD; aw_wr = aWr;
        end
        if (rfReq && rf_keep) rf_w = 1;
        if (!b_pend || g_b) starve = 0;
        else if (g_a && starve < STARVE) starve++;
        e_rf = n_rf; e_rd = n_rd; e_wr = n_wr; e_aack = n_aack; e_back = n_back;
    endtask

    task automatic cyc();
        @(posedge clock);
        if (!reset) m_reset();
        else        m_edge();
        @(negedge clock);
        ncyc++;
        chk("ctl", 64'({sdrRf, sdrRd, sdrWr, aAck, bAck}), 64'({e_rf, e_rd, e_wr, e_aack, e_back}));
        chk("sdrA", 64'(sdrA), 64'(e_sdrA));
        chk("sdrD", 64'(sdrD), 64'(e_sdrD));
        chk("aQ", 64'(aQ), 64'(e_aQ));
        chk("bQ", 64'(bQ), 64'(e_bQ));
        if (sdrRf | sdrRd | sdrWr) begin
            t_cmd.push_back(ncyc);
            k_cmd.push_back({sdrRf, sdrRd, sdrWr});
            d_cmd.push_back(sdrD);
        end
        if (bAck) bReq = 1'b0;
        aRd = 1'b0; aWr = 1'b0; rfReq = 1'b0;
    endtask

    initial begin
        int n;
        bit found;
        logic [1:0] r;
        m_reset();

        repeat (3) cyc();
        chk("rst_ctl", 64'({sdrRf, sdrRd, sdrWr, aAck, bAck}), 64'd0);
        chk("rst_data", 64'({aQ, bQ, sdrD}), 64'd0);
        chk("rst_addr", 64'(sdrA), 64'd0);
        reset = 1'b1; ready = 1'b1;
        cyc();

        // CPU read: command next cycle, ack CYC cycles later with low byte.
        sdrQ = 16'hBEEF; aA = 24'h000123; aRd = 1'b1;
        cyc();
        chk("r039_rd", 64'(sdrRd), 64'd1);
        chk("r039_addr", 64'(sdrA), 64'h000123);
        repeat (CYC) cyc();
        chk("r039_ack", 64'(aAck), 64'd1);
        chk("r039_aq", 64'(aQ), 64'hEF);
        repeat (2) cyc();

        // Simultaneous refresh, CPU write and DMA write.
        t_cmd.delete(); k_cmd.delete(); d_cmd.delete();
        rfReq = 1'b1; aWr = 1'b1; aD = 8'h5A; aA = 24'h00ABCD;
        bReq = 1'b1; bWe = 1'b1; bA = 24'h777777; bD = 16'h1234;
        repeat (3 * (CYC + 1) + 3) cyc();
        chk("r040_n", 64'(t_cmd.size()), 64'd3);
        chk("r040_k0", 64'(k_cmd[0]), 64'(3'b100));
        chk("r040_k1", 64'(k_cmd[1]), 64'(3'b001));
        chk("r040_d1", 64'(d_cmd[1]), 64'h5A5A);
        chk("r040_k2", 64'(k_cmd[2]), 64'(3'b001));
        chk("r040_d2", 64'(d_cmd[2]), 64'h1234);
        chk("r040_gap1", 64'(t_cmd[1] - t_cmd[0]), 64'(CYC + 1));
        chk("r040_gap2", 64'(t_cmd[2] - t_cmd[1]), 64'(CYC + 1));

        // Continuous CPU writes against a held DMA read.
        bReq = 1'b1; bWe = 1'b0; bA = 24'h0D0D0D;
        n = 0; found = 0;
        for (int i = 0; i < (STARVE + 3) * (CYC + 1); i++) begin
            aWr = 1'b1; aA = 24'($urandom); aD = 8'($urandom); sdrQ = 16'($urandom);
            cyc();
            if (sdrRd) begin
                found = 1;
                break;
            end
            if (sdrWr) n++;
        end
        chk("r041_found", 64'(found), 64'd1);
        chk("r041_agrants", 64'(n), 64'(STARVE));
        repeat (3 * (CYC + 1)) cyc();

        // No grants while not ready.
        ready = 1'b0; aRd = 1'b1; aA = 24'h00F00D;
        t_cmd.delete();
        repeat (7) cyc();
        chk("r042_quiet", 64'(t_cmd.size()), 64'd0);
        ready = 1'b1;
        cyc();
        chk("r042_rd", 64'(sdrRd), 64'd1);
        repeat (CYC + 2) cyc();

        // Abort a DMA read mid-flight and retry.
        bReq = 1'b1; bWe = 1'b0; bA = 24'h00B0B0; sdrQ = 16'h1111;
        cyc();
        cyc();
        ready = 1'b0;
        cyc();
        chk("r043_noack", 64'(bAck), 64'd0);
        cyc();
        sdrQ = 16'h2222; ready = 1'b1;
        found = 0;
        for (int i = 0; i < 4 * CYC; i++) begin
            cyc();
            if (bAck) begin
                found = 1;
                break;
            end
        end
        chk("r043_ack", 64'(found), 64'd1);
        chk("r043_bq", 64'(bQ), 64'h2222);
        repeat (2) cyc();

        // Asynchronous reset in the middle of a command.
        bReq = 1'b1; bWe = 1'b0; bA = 24'h00C0C0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("r044_ctl", 64'({sdrRf, sdrRd, sdrWr, aAck, bAck}), 64'd0);
        chk("r044_data", 64'({aQ, bQ, sdrD}), 64'd0);
        chk("r044_addr", 64'(sdrA), 64'd0);
        bReq = 1'b0;
        cyc();
        reset = 1'b1;
        t_cmd.delete();
        repeat (10) cyc();
        chk("r044_idle", 64'(t_cmd.size()), 64'd0);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = 2'($urandom_range(1, 3));
                aRd = r[0]; aWr = r[1];
                aA = 24'($urandom); aD = 8'($urandom);
            end
            rfReq = ($urandom_range(0, 19) == 0);
            if (!bReq && $urandom_range(0, 7) == 0) begin
                bReq = 1'b1; bWe = 1'($urandom); bA = 24'($urandom); bD = 16'($urandom);
            end
            if (ready && $urandom_range(0, 59) == 0)       ready = 1'b0;
            else if (!ready && $urandom_range(0, 2) == 0) ready = 1'b1;
            sdrQ = 16'($urandom);
            cyc();
        end

        ready = 1'b1;
        repeat (60) cyc();
        chk("drain_b", 64'(bReq), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter CYC, default 8: clocks per controller command; the legal range is 2..15.
REQ-002 Parameter STARVE, default 4: consecutive port-A grants allowed while port B is pending.
REQ-003 clock  in  1  system clock; all logic on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ready  in  1  SDRAM controller initialisation done.
REQ-006 aRd, aWr  in  1 each  CPU-port single-cycle read/write strobes.
REQ-007 aA  in  24  CPU-port address; aD  in  8  CPU-port write data.
REQ-008 aQ  out  8  CPU-port read data; aAck  out  1  one-cycle completion pulse.
REQ-009 bReq  in  1  DMA/loader request, level, held until bAck.
REQ-010 bWe  in  1  DMA write when high, read when low; sampled with bReq.
REQ-011 bA  in  24  DMA address; bD  in  16  DMA write data.
REQ-012 bQ  out  16  DMA read data; bAck  out  1  one-cycle completion pulse.
REQ-013 rfReq  in  1  single-cycle refresh request strobe.
REQ-014 sdrRf, sdrRd, sdrWr  out  1 each  controller command strobes, one-cycle.
REQ-015 sdrA  out  24  controller address; sdrD  out  16  controller write data.
REQ-016 sdrQ  in  16  controller read data, valid on the last BUSY cycle.

Function
REQ-017 Pending latches: aPend is set by aRd|aWr and captures aA, aD and the direction; rfPend is set by rfReq; B is pending while bReq is high and bAck is not being pulsed.
REQ-018 A strobe arriving while aPend is set and not yet granted SHALL overwrite the captured address, data and direction (latest wins).
REQ-019 A strobe arriving in the same cycle as an A grant SHALL set aPend again for the next grant.
REQ-020 FSM states: IDLE, BUSY, DONE.
REQ-021 IDLE transition: if ready is high and any request is pending, go to BUSY, pulse exactly one sdr strobe, drive sdrA/sdrD, and load the counter with CYC-2.
REQ-022 Grant priority is rfPend > A > B.
REQ-023 Starvation override: when the starvation counter equals STARVE and B is pending, B SHALL win over A (refresh is still first).
REQ-024 Starvation counter: increments on each A grant while B is pending; clears on a B grant or whenever B is not pending; saturates at STARVE.
REQ-025 Refresh grant: sdrRf pulses and sdrA/sdrD hold their previous values.
REQ-026 A grant drives sdrA = captured aA and sdrD = {2{captured aD}}; B grant drives sdrA = bA and sdrD = bD.
REQ-027 BUSY: decrement the counter; at zero, latch sdrQ and go to DONE.
REQ-028 Read latching: an A read latches sdrQ[7:0] into aQ; a B read latches sdrQ into bQ.
REQ-029 Writes and refreshes SHALL leave aQ and bQ unchanged.
REQ-030 DONE: pulse aAck or bAck for the granted port (none for refresh), clear that port's pending state, and return to IDLE.
REQ-031 Latency: command strobe at cycle t, ack at t+CYC, next command no earlier than t+CYC+1.
REQ-032 No grant SHALL be issued while ready is low; pending state is retained.
REQ-033 If ready falls in BUSY or DONE, abort to IDLE the next cycle with no ack; the aborted request stays pending and is retried once ready is high.
REQ-034 aQ and bQ hold their values between accesses.
REQ-035 When aRd and aWr are both asserted in one cycle, write takes precedence.
REQ-036 A refresh strobe arriving while rfPend is already set is merged into it (no count kept).

Reset
REQ-037 While reset is low: state IDLE; all pending bits, counters and the starvation count at 0; all sdr* outputs, aAck, bAck, aQ and bQ at 0.
REQ-038 After reset rises, the first grant occurs no earlier than the first cycle in which ready is high.

Verification
REQ-039 ready=1, aRd at t0 with aA=0x000123, sdrQ=0xBEEF at the last BUSY cycle -> sdrRd at t0+1 with sdrA=0x000123, aQ=0xEF, aAck at t0+1+CYC.
REQ-040 rfReq, aWr (aD=0x5A) and bReq all in one cycle -> command order sdrRf, sdrWr with sdrD=0x5A5A, then the B command; each command is CYC+1 cycles apart.
REQ-041 aWr strobed continuously every CYC+1 cycles with bReq held -> B is granted after exactly STARVE A grants; the starvation counter then clears.
REQ-042 ready=0 with aRd pending -> no sdr strobes; raise ready -> sdrRd on the next cycle.
REQ-043 Drop ready in mid-BUSY of a B read -> no bAck; the B command is reissued once ready returns; bQ is updated only by the retry.
REQ-044 Assert reset during BUSY -> all outputs are 0 immediately (asynchronously); after release, nothing is issued until a new request arrives.
